// File: rtl/width_widening_adapter.sv
// width_widening_adapter: packs SYMBOLS narrow Avalon-ST beats into one wide beat, first symbol in the LSBs.
module width_widening_adapter #(
    parameter int  ST_SINK_WIDTH   = 8,
    parameter int  ST_SOURCE_WIDTH = 16,
    localparam int SYMBOLS         = ST_SOURCE_WIDTH / ST_SINK_WIDTH,
    localparam int EMPTY_WIDTH     = (SYMBOLS > 2) ? $clog2(SYMBOLS) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    output logic                       st_sink_ready,
    input  logic [ST_SINK_WIDTH-1:0]   st_sink_data,
    input  logic                       st_sink_startofpacket,
    input  logic                       st_sink_endofpacket,
    input  logic                       st_sink_valid,
    input  logic                       st_source_ready,
    output logic [ST_SOURCE_WIDTH-1:0] st_source_data,
    output logic                       st_source_startofpacket,
    output logic                       st_source_endofpacket,
    output logic [EMPTY_WIDTH-1:0]     st_source_empty,
    output logic                       st_source_valid,
    output logic                       protocol_error
);
    localparam int SW = ST_SINK_WIDTH;
    localparam logic [EMPTY_WIDTH-1:0] LAST = EMPTY_WIDTH'(SYMBOLS - 1);

    if (ST_SOURCE_WIDTH % ST_SINK_WIDTH != 0 || ST_SOURCE_WIDTH <= ST_SINK_WIDTH) begin : g_bad_width
        $fatal(1, "ST_SOURCE_WIDTH must be an integer multiple (>1) of ST_SINK_WIDTH");
    end

    logic [(SYMBOLS-1)*SW-1:0] acc;
    logic [EMPTY_WIDTH-1:0]    fill;
    logic [EMPTY_WIDTH-1:0]    fill_eff;
    logic                      acc_sop;
    logic                      in_packet;
    logic                      accept;
    logic                      mid_sop;
    logic                      complete;
    logic [ST_SOURCE_WIDTH-1:0] word;

    assign st_sink_ready = !st_source_valid || st_source_ready;
    assign accept        = st_sink_valid && st_sink_ready;
    assign mid_sop       = accept && st_sink_startofpacket && (in_packet || fill != '0);
    // a mid-packet SOP throws away the partial word and restarts at slot 0
    assign fill_eff      = mid_sop ? '0 : fill;
    assign complete      = accept && (fill_eff == LAST || st_sink_endofpacket);

    always_comb begin
        word = '0;
        for (int i = 0; i < SYMBOLS - 1; i++)
            if (EMPTY_WIDTH'(i) < fill_eff) word[i*SW +: SW] = acc[i*SW +: SW];
        for (int i = 0; i < SYMBOLS; i++)
            if (EMPTY_WIDTH'(i) == fill_eff) word[i*SW +: SW] = st_sink_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc                     <= '0;
            fill                    <= '0;
            acc_sop                 <= 1'b0;
            in_packet               <= 1'b0;
            st_source_data          <= '0;
            st_source_startofpacket <= 1'b0;
            st_source_endofpacket   <= 1'b0;
            st_source_empty         <= '0;
            st_source_valid         <= 1'b0;
            protocol_error          <= 1'b0;
        end else begin
            protocol_error <= mid_sop;
            if (accept) begin
                in_packet <= st_sink_endofpacket ? 1'b0 : (st_sink_startofpacket ? 1'b1 : in_packet);
                fill      <= complete ? '0 : fill_eff + 1'b1;
                if (!complete) begin
                    for (int i = 0; i < SYMBOLS - 1; i++)
                        if (fill_eff == EMPTY_WIDTH'(i)) acc[i*SW +: SW] <= st_sink_data;
                    if (fill_eff == '0) acc_sop <= st_sink_startofpacket;
                end
            end
            if (complete) begin
                st_source_data          <= word;
                st_source_startofpacket <= (fill_eff == '0) ? st_sink_startofpacket : acc_sop;
                st_source_endofpacket   <= st_sink_endofpacket;
                st_source_empty         <= st_sink_endofpacket ? LAST - fill_eff : '0;
                st_source_valid         <= 1'b1;
            end else if (st_source_ready) begin
                st_source_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_width_widening_adapter.sv
// tb_width_widening_adapter: scoreboard bench for 8->16 and 8->32 widening adapters.
module tb_width_widening_adapter;
    typedef struct packed {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int perr16 = 0;
    exp_t q16[$];
    exp_t q32[$];
    exp_t e16, e32;
    logic rand_en = 1'b0;
    logic hold16 = 1'b0;
    logic [15:0] hold_d16;

    logic        k16, s16_sop, s16_eop, s16_valid, r16;
    logic [7:0]  s16_data;
    logic [15:0] o16_data;
    logic        o16_sop, o16_eop, o16_valid, pe16;
    logic [0:0]  o16_empty;

    logic        k32, s32_sop, s32_eop, s32_valid, r32;
    logic [7:0]  s32_data;
    logic [31:0] o32_data;
    logic        o32_sop, o32_eop, o32_valid, pe32;
    logic [1:0]  o32_empty;

    width_widening_adapter #(.ST_SINK_WIDTH(8), .ST_SOURCE_WIDTH(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .st_sink_ready(k16), .st_sink_data(s16_data),
        .st_sink_startofpacket(s16_sop), .st_sink_endofpacket(s16_eop), .st_sink_valid(s16_valid),
        .st_source_ready(r16), .st_source_data(o16_data), .st_source_startofpacket(o16_sop),
        .st_source_endofpacket(o16_eop), .st_source_empty(o16_empty), .st_source_valid(o16_valid),
        .protocol_error(pe16)
    );

    width_widening_adapter #(.ST_SINK_WIDTH(8), .ST_SOURCE_WIDTH(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .st_sink_ready(k32), .st_sink_data(s32_data),
        .st_sink_startofpacket(s32_sop), .st_sink_endofpacket(s32_eop), .st_sink_valid(s32_valid),
        .st_source_ready(r32), .st_source_data(o32_data), .st_source_startofpacket(o32_sop),
        .st_source_endofpacket(o32_eop), .st_source_empty(o32_empty), .st_source_valid(o32_valid),
        .protocol_error(pe32)
    );

    always @(posedge clk) if (rand_en) begin
        #1;
        r16 = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            hold16 = 1'b0;
        end else begin
            if (pe16) perr16++;
            if (hold16) begin
                checks++;
                if (o16_valid !== 1'b1 || o16_data !== hold_d16) begin
                    errors++;
                    $display("FAIL hold16 valid=%b data=%h required valid=1 data=%h", o16_valid, o16_data, hold_d16);
                end
            end
            hold16 = o16_valid && !r16;
            hold_d16 = o16_data;
            if (o16_valid && r16) begin
                checks++;
                if (q16.size() == 0) begin
                    errors++;
                    $display("FAIL out16 unexpected word %h", o16_data);
                end else begin
                    e16 = q16.pop_front();
                    if ({o16_data, o16_sop, o16_eop, o16_empty} !== {e16.d[15:0], e16.sop, e16.eop, e16.empty[0]}) begin
                        errors++;
                        $display("FAIL out16 got %h sop=%b eop=%b empty=%0d required %h sop=%b eop=%b empty=%0d",
                                 o16_data, o16_sop, o16_eop, o16_empty, e16.d[15:0], e16.sop, e16.eop, e16.empty[0]);
                    end
                end
            end
            if (o32_valid && r32) begin
                checks++;
                if (q32.size() == 0) begin
                    errors++;
                    $display("FAIL out32 unexpected word %h", o32_data);
                end else begin
                    e32 = q32.pop_front();
                    if ({o32_data, o32_sop, o32_eop, o32_empty} !== {e32.d, e32.sop, e32.eop, e32.empty}) begin
                        errors++;
                        $display("FAIL out32 got %h sop=%b eop=%b empty=%0d required %h sop=%b eop=%b empty=%0d",
                                 o32_data, o32_sop, o32_eop, o32_empty, e32.d, e32.sop, e32.eop, e32.empty);
                    end
                end
            end
        end
    end

    task automatic beat16(input logic [7:0] d, input logic sop, input logic eop);
        int n = 0;
        s16_data = d; s16_sop = sop; s16_eop = eop; s16_valid = 1'b1;
        @(negedge clk);
        while (!k16 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!k16) begin
            errors++;
            $display("FAIL beat16 timeout ready=%b required 1", k16);
        end
        @(posedge clk); #1;
        s16_valid = 1'b0; s16_sop = 1'b0; s16_eop = 1'b0;
    endtask

    task automatic beat32(input logic [7:0] d, input logic sop, input logic eop);
        int n = 0;
        s32_data = d; s32_sop = sop; s32_eop = eop; s32_valid = 1'b1;
        @(negedge clk);
        while (!k32 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!k32) begin
            errors++;
            $display("FAIL beat32 timeout ready=%b required 1", k32);
        end
        @(posedge clk); #1;
        s32_valid = 1'b0; s32_sop = 1'b0; s32_eop = 1'b0;
    endtask

    task automatic push16(input logic [15:0] d, input logic sop, input logic eop, input logic [1:0] empty);
        q16.push_back('{d: {16'h0, d}, sop: sop, eop: eop, empty: empty});
    endtask

    task automatic push32(input logic [31:0] d, input logic sop, input logic eop, input logic [1:0] empty);
        q32.push_back('{d: d, sop: sop, eop: eop, empty: empty});
    endtask

    task automatic test_reset;
        s16_data = '0; s16_sop = 0; s16_eop = 0; s16_valid = 0; r16 = 1;
        s32_data = '0; s32_sop = 0; s32_eop = 0; s32_valid = 0; r32 = 1;
        reset_n = 1'b0;
        #12;
        checks++;
        if ({o16_valid, o16_data, o16_sop, o16_eop, o16_empty, pe16, k16} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset16 valid=%b data=%h sop=%b eop=%b empty=%0d perr=%b ready=%b required all 0, ready=1",
                     o16_valid, o16_data, o16_sop, o16_eop, o16_empty, pe16, k16);
        end
        checks++;
        if ({o32_valid, o32_data, o32_sop, o32_eop, o32_empty, pe32, k32} !== {1'b0, 32'h0, 1'b0, 1'b0, 2'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset32 valid=%b data=%h sop=%b eop=%b empty=%0d perr=%b ready=%b required all 0, ready=1",
                     o32_valid, o32_data, o32_sop, o32_eop, o32_empty, pe32, k32);
        end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic16;
        push16(16'h2211, 1, 0, 0);
        push16(16'h4433, 0, 1, 0);
        beat16(8'h11, 1, 0);
        beat16(8'h22, 0, 0);
        checks++;
        if (o16_valid !== 1'b1 || o16_data !== 16'h2211) begin
            errors++;
            $display("FAIL latency16_w0 valid=%b data=%h required valid=1 data=2211", o16_valid, o16_data);
        end
        beat16(8'h33, 0, 0);
        checks++;
        if (o16_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid16_valid valid=%b required 0", o16_valid);
        end
        beat16(8'h44, 0, 1);
        checks++;
        if (o16_valid !== 1'b1 || o16_data !== 16'h4433) begin
            errors++;
            $display("FAIL latency16_w1 valid=%b data=%h required valid=1 data=4433", o16_valid, o16_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_partial16;
        push16(16'hBBAA, 1, 0, 0);
        push16(16'h00CC, 0, 1, 1);
        beat16(8'hAA, 1, 0);
        beat16(8'hBB, 0, 0);
        beat16(8'hCC, 0, 1);
        checks++;
        if (o16_data !== 16'h00CC || o16_empty !== 1'b1 || o16_eop !== 1'b1) begin
            errors++;
            $display("FAIL partial16 data=%h empty=%0d eop=%b required 00CC empty=1 eop=1", o16_data, o16_empty, o16_eop);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single32;
        push32(32'h0000005A, 1, 1, 3);
        beat32(8'h5A, 1, 1);
        checks++;
        if (o32_valid !== 1'b1 || o32_data !== 32'h5A || o32_empty !== 2'd3 || k32 !== 1'b1) begin
            errors++;
            $display("FAIL single32 valid=%b data=%h empty=%0d ready=%b required 1/0000005A/3/1", o32_valid, o32_data, o32_empty, k32);
        end
        push32(32'hA4A3A2A1, 1, 0, 0);
        push32(32'h0000A6A5, 0, 1, 2);
        beat32(8'hA1, 1, 0);
        for (int i = 2; i <= 5; i++) beat32(8'hA0 + 8'(i), 0, 0);
        beat32(8'hA6, 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        r16 = 1'b0;
        push16(16'h2211, 1, 0, 0);
        push16(16'h4433, 0, 1, 0);
        beat16(8'h11, 1, 0);
        beat16(8'h22, 0, 0);
        fork
            begin
                beat16(8'h33, 0, 0);
                beat16(8'h44, 0, 1);
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    checks++;
                    if (k16 !== 1'b0 || o16_valid !== 1'b1 || o16_data !== 16'h2211) begin
                        errors++;
                        $display("FAIL stall16 ready=%b valid=%b data=%h required 0/1/2211", k16, o16_valid, o16_data);
                    end
                end
                @(posedge clk); #1;
                r16 = 1'b1;
            end
        join
        @(posedge clk); #1;
    endtask

    task automatic test_mid_sop;
        int p0 = perr16;
        push16(16'h0302, 1, 1, 0);
        beat16(8'h01, 1, 0);
        beat16(8'h02, 1, 0);
        beat16(8'h03, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (perr16 - p0 !== 1) begin
            errors++;
            $display("FAIL midsop_pulses got %0d required 1", perr16 - p0);
        end
    endtask

    task automatic test_async_reset;
        int p0;
        beat16(8'h11, 1, 0);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (o16_valid !== 1'b0 || k16 !== 1'b1) begin
            errors++;
            $display("FAIL areset16 valid=%b ready=%b required 0/1", o16_valid, k16);
        end
        @(posedge clk); #3 reset_n = 1'b1;
        @(posedge clk); #1;
        p0 = perr16;
        push16(16'h8877, 1, 1, 0);
        beat16(8'h77, 1, 0);
        beat16(8'h88, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (perr16 !== p0 || q16.size() !== 0) begin
            errors++;
            $display("FAIL after_reset16 perr=%0d pending=%0d required 0/0", perr16 - p0, q16.size());
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] b, prev;
        int len;
        rand_en = 1'b1;
        for (int p = 0; p < 20; p++) begin
            len = $urandom_range(1, 5);
            prev = '0;
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                if (i % 2 == 1) push16({b, prev}, i == 1, i == len - 1, 0);
                else if (i == len - 1) push16({8'h00, b}, i == 0, 1, 1);
                beat16(b, i == 0, i == len - 1);
                prev = b;
            end
        end
        rand_en = 1'b0;
        @(posedge clk); #2;
        r16 = 1'b1;
        for (int n = 0; n < 50 && q16.size() != 0; n++) @(posedge clk);
        #1;
        checks++;
        if (q16.size() !== 0) begin
            errors++;
            $display("FAIL drain16 pending=%0d required 0", q16.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic16();
        test_partial16();
        test_single32();
        test_backpressure();
        test_mid_sop();
        test_async_reset();
        test_back_to_back();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (q16.size() + q32.size() !== 0) begin
            errors++;
            $display("FAIL leftover pending16=%0d pending32=%0d required 0", q16.size(), q32.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/width_widening_adapter.md
Name: width_widening_adapter

Overview:
- Avalon-ST packer. Gathers SYMBOLS consecutive narrow sink beats into one wide source beat.
- The first symbol received goes in the least significant bits, so this block is the inverse of the existing width narrowing adapter.
- A packet whose length is not a multiple of SYMBOLS ends with a partial word, flagged by st_source_empty.
- Sits between byte-oriented producers (e.g. a UART/byte FIFO) and 16/32-bit pixel or memory-write paths in the VGA pipeline.

Parameters:
- ST_SINK_WIDTH, 8, width of one narrow input symbol.
- ST_SOURCE_WIDTH, 16, width of the output word; must be an integer multiple (>1) of ST_SINK_WIDTH, otherwise $fatal at elaboration.
- Derived localparam SYMBOLS = ST_SOURCE_WIDTH/ST_SINK_WIDTH.
- Derived localparam EMPTY_WIDTH = max(1, $clog2(SYMBOLS)).

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous, active-low reset.
- st_sink_ready  output  1  sink may present a symbol.
- st_sink_data  input  ST_SINK_WIDTH  input symbol.
- st_sink_startofpacket  input  1  first symbol of packet.
- st_sink_endofpacket  input  1  last symbol of packet.
- st_sink_valid  input  1  sink beat valid.
- st_source_ready  input  1  downstream accepts word.
- st_source_data  output  ST_SOURCE_WIDTH  packed word, symbol 0 in LSBs.
- st_source_startofpacket  output  1  word holds first symbol of packet.
- st_source_endofpacket  output  1  word holds last symbol of packet.
- st_source_empty  output  EMPTY_WIDTH  number of unused upper symbol slots (0 unless eop).
- st_source_valid  output  1  word valid.
- protocol_error  output  1  one-cycle pulse on an SOP arriving mid-packet.

Behaviour:
- Reset (reset_n low, asynchronous): accumulator, fill count, sop flag, output register, valid and protocol_error all cleared. All outputs read 0 except st_sink_ready, which reads 1 after reset.
- State:
  - Accumulator: SYMBOLS-1 symbol slots.
  - fill count 0..SYMBOLS-1.
  - acc_sop flag.
  - in_packet flag.
  - Output register: data, sop, eop, empty, valid.
- out_free = !st_source_valid || st_source_ready.
- st_sink_ready = out_free. This is combinational from st_source_ready only, never from sink inputs.
- Accept = st_sink_valid && st_sink_ready.
- On accept, the symbol is written to slot[fill]. The word completes when fill == SYMBOLS-1 or st_sink_endofpacket.
- Non-completing accept:
  - Store the symbol and increment fill.
  - If fill == 0, latch acc_sop = st_sink_startofpacket.
- Completing accept, all in the same cycle:
  - Output register loads accumulator slots 0..fill-1 plus the incoming symbol in slot[fill]. Unused upper slots are zero.
  - sop = (fill==0 ? st_sink_startofpacket : acc_sop).
  - eop = st_sink_endofpacket.
  - empty = eop ? SYMBOLS-1-fill : 0.
  - valid = 1.
  - fill returns to 0.
- Latency: the word is valid on the cycle after the completing symbol is accepted.
- Throughput: one symbol per clock while st_source_ready is held high.
- If out_free is 0, no symbol is accepted. Output data, sop, eop and empty stay stable while valid && !ready.
- If the output is consumed with no new completing accept in that cycle, valid clears.
- in_packet is set on an accepted sop and cleared on an accepted eop.
- Mid-packet SOP: an accepted SOP while in_packet == 1 or fill != 0:
  - The partial accumulator is discarded (fill reset) and protocol_error pulses for one cycle.
  - The new symbol starts a fresh word at slot 0 with acc_sop = 1.
- Single-symbol packet (sop && eop on one beat) completes immediately with empty = SYMBOLS-1 and both sop and eop set on the output word.
- Symbols arriving while not in_packet and without SOP are packed normally with sop = 0. No error is raised.
- Reset mid-packet discards all partial state immediately. No word is emitted.

Decomposition:
- No shared package needed. SYMBOLS and EMPTY_WIDTH are localparams.
- The parameter-check assertion matches the narrowing adapter's rule (multiple, strictly wider).
- No sub-module: accumulator and output register are a single always_ff with async reset. An optional generate loop handles per-slot writes.

Test Plan:
- 8->16, packet 0x11,0x22,0x33,0x44 (sop on 0x11, eop on 0x44), ready=1 → words 0x2211 (sop=1,eop=0,empty=0) then 0x4433 (sop=0,eop=1,empty=0), each one cycle after its second byte.
- 8->16, packet 0xAA,0xBB,0xCC (eop on 0xCC) → 0xBBAA sop; 0x00CC eop, empty=1.
- 8->32, single beat 0x5A with sop+eop → 0x0000005A, sop=1, eop=1, empty=3; st_sink_ready stays 1.
- Backpressure, 8->16: st_source_ready=0 while the first word is valid.
  - st_sink_ready drops.
  - Data is held stable for 5 cycles.
  - Raising ready yields the first word, and streaming resumes with no symbol loss or duplication.
- Mid-packet SOP, 8->16: 0x01 (sop), then 0x02 (sop), 0x03 (eop) → protocol_error pulses once; only word 0x0302 is emitted, with sop=1, eop=1, empty=0.
- Assert reset_n low asynchronously after byte 0x11 of a packet, then release → st_source_valid=0 and no word is emitted; a following packet 0x77,0x88 yields 0x8877 correctly.
